// File: rtl/prbs_pkg.sv
// Shared constants and types for the 16-bit-per-advance x31+x28 XNOR PRBS generator and checker.
package prbs_pkg;
  typedef enum logic [1:0] {IDLE, ARM, RUN} fsm_e;

  localparam int          TAP_A  = 31;
  localparam int          TAP_B  = 28;
  localparam int          WORD_W = 16;
  localparam logic [30:0] LOCKUP = 31'h7FFF_FFFF;

  // All-ones is the XNOR fixed point, so it is swapped for the default seed.
  function automatic logic [30:0] legal_seed(input logic [30:0] s, input logic [30:0] dflt);
    return (s == LOCKUP) ? dflt : s;
  endfunction
endpackage

// File: rtl/prbs_tx_16_2v31_x31_x28_1_if.sv
// Control/data bundle of the PRBS transmitter; master drives the controls.
interface prbs_tx_16_2v31_x31_x28_1_if;
  import prbs_pkg::*;
  logic              ce;
  logic              en;
  logic              seed_load;
  logic [30:0]       seed;
  logic              inj_err;
  logic [WORD_W-1:0] q;
  logic              q_valid;
  logic              busy;
  logic [31:0]       word_cnt;
  logic [15:0]       inj_cnt;

  modport master (output ce, en, seed_load, seed, inj_err,
                  input  q, q_valid, busy, word_cnt, inj_cnt);
  modport slave  (input  ce, en, seed_load, seed, inj_err,
                  output q, q_valid, busy, word_cnt, inj_cnt);
endinterface

// File: rtl/prbs31_step16.sv
// Combinational 16-bit advance of b[n] = b[n-31] XNOR b[n-28]; state_in[0] is the newest bit.
module prbs31_step16
  import prbs_pkg::*;
(
  input  logic [30:0]       state_in,
  output logic [30:0]       state_out,
  output logic [WORD_W-1:0] word
);
  always_comb begin
    logic [30:0] s;
    logic        fb;
    s    = state_in;
    fb   = 1'b0;
    word = '0;
    // First generated bit ends up in word[WORD_W-1].
    for (int i = 0; i < WORD_W; i++) begin
      fb   = s[TAP_A-1] ~^ s[TAP_B-1];
      s    = {s[29:0], fb};
      word = {word[WORD_W-2:0], fb};
    end
    state_out = s;
  end
endmodule

// File: rtl/prbs_tx_16_2v31_x31_x28_1.sv
// PRBS31 (x31+x28, XNOR) word transmitter with IDLE/ARM/RUN control and single-bit error injection.
module prbs_tx_16_2v31_x31_x28_1
  import prbs_pkg::*;
#(
  parameter logic [30:0] SEED_DEFAULT = 31'h0000_FFFF
) (
  input  logic              C,
  input  logic              R_N,
  input  logic              CE,
  input  logic              EN,
  input  logic              SEED_LOAD,
  input  logic [30:0]       SEED,
  input  logic              INJ_ERR,
  output logic [WORD_W-1:0] Q,
  output logic              Q_VALID,
  output logic              BUSY,
  output logic [31:0]       WORD_CNT,
  output logic [15:0]       INJ_CNT
);
  fsm_e              fsm_q, fsm_d;
  logic [30:0]       lfsr, lfsr_nxt;
  logic [WORD_W-1:0] word_nxt, q;
  logic              q_valid, pend, emit;
  logic [31:0]       word_cnt;
  logic [15:0]       inj_cnt;

  prbs31_step16 u_step (.state_in(lfsr), .state_out(lfsr_nxt), .word(word_nxt));

  assign emit = (fsm_q == RUN) && CE;

  always_ff @(posedge C or negedge R_N) begin
    if (!R_N) fsm_q <= IDLE;
    else      fsm_q <= fsm_d;
  end

  // A seed load in IDLE wins over the arm request of the same cycle.
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (!SEED_LOAD && EN) fsm_d = ARM;
      ARM:     fsm_d = EN ? RUN : IDLE;
      RUN:     if (!EN) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge C or negedge R_N) begin
    if (!R_N) begin
      lfsr     <= SEED_DEFAULT;
      q        <= '0;
      q_valid  <= 1'b0;
      word_cnt <= '0;
      inj_cnt  <= '0;
      pend     <= 1'b0;
    end else begin
      q_valid <= emit;
      if (fsm_q == IDLE && SEED_LOAD) lfsr <= legal_seed(SEED, SEED_DEFAULT);
      if (fsm_q == ARM) word_cnt <= '0;
      // Injection only touches the registered word, never the generator state.
      if (emit) begin
        lfsr <= lfsr_nxt;
        q    <= word_nxt ^ {{(WORD_W-1){1'b0}}, pend};
        if (word_cnt != '1) word_cnt <= word_cnt + 32'd1;
        if (pend && inj_cnt != '1) inj_cnt <= inj_cnt + 16'd1;
      end
      if (fsm_q != RUN || fsm_d != RUN) pend <= 1'b0;
      else if (emit)                    pend <= pend ? 1'b0 : INJ_ERR;
      else                              pend <= pend | INJ_ERR;
    end
  end

  assign Q        = q;
  assign Q_VALID  = q_valid;
  assign BUSY     = (fsm_q != IDLE);
  assign WORD_CNT = word_cnt;
  assign INJ_CNT  = inj_cnt;
endmodule
